// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx_if
//  Description : Command handshake between a host controller and the PS/2
//                host-to-device transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_host_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;
    logic       rx_en;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_busy,
        input  tx_done,
        input  tx_err,
        input  rx_en
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_busy,
        output tx_done,
        output tx_err,
        output rx_en
    );
endinterface
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx
//  Description : PS/2 host-to-device command transmitter (request-to-send,
//                11-edge frame, acknowledge check, inactivity timeout).
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  wire          clk,
    input  wire          rst,
    input  wire          ps2_clk_in,
    input  wire          ps2_dat_in,
    ps2_host_tx_if.slave bus,
    output logic         ps2_clk_oe,
    output logic         ps2_dat_oe
);

    localparam int c_cnt_max = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam logic [c_cnt_w-1:0] c_inh_last = c_cnt_w'(INHIBIT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_tmo_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_START     = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    state_t               r_state;
    logic [7:0]           r_clk_shift;
    logic                 r_clk_filt;
    logic [1:0]           r_dat_sync;
    logic [9:0]           r_frame;
    logic [3:0]           r_bitcnt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_ack_ok;
    logic                 r_clk_oe;
    logic                 r_dat_oe;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;
    logic                 w_fall;
    logic                 w_dat;

    // Clock deglitcher: the filtered level only moves after 8 identical samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_shift <= 8'hFF;
            r_clk_filt  <= 1'b1;
            r_dat_sync  <= 2'b11;
        end else begin
            r_clk_shift <= {r_clk_shift[6:0], ps2_clk_in};
            r_dat_sync  <= {r_dat_sync[0], ps2_dat_in};
            if (r_clk_shift == 8'hFF) begin
                r_clk_filt <= 1'b1;
            end else if (r_clk_shift == 8'h00) begin
                r_clk_filt <= 1'b0;
            end
        end
    end

    assign w_fall = r_clk_filt & (r_clk_shift == 8'h00);
    assign w_dat  = r_dat_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_frame  <= '1;
            r_bitcnt <= '0;
            r_cnt    <= '0;
            r_ack_ok <= 1'b0;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_clk_oe <= 1'b0;
                    r_dat_oe <= 1'b0;
                    if (bus.tx_start) begin
                        r_frame  <= {1'b1, ~^bus.tx_data, bus.tx_data};
                        r_bitcnt <= '0;
                        r_cnt    <= '0;
                        r_clk_oe <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    // Filter sees our own low clock here; edges are ignored.
                    if (r_cnt == c_inh_last) begin
                        r_cnt    <= '0;
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b1;
                        r_state  <= ST_START;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    // Timeout is checked first so it wins over a coincident edge.
                    if (r_cnt == c_tmo_last) begin
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_err    <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_cnt <= w_fall ? '0 : r_cnt + 1'b1;
                        case (r_state)
                            ST_START: begin
                                if (w_fall) begin
                                    r_dat_oe <= ~r_frame[0];
                                    r_frame  <= {1'b1, r_frame[9:1]};
                                    r_bitcnt <= 4'd1;
                                    r_state  <= ST_SHIFT;
                                end
                            end
                            ST_SHIFT: begin
                                if (w_fall) begin
                                    r_dat_oe <= ~r_frame[0];
                                    r_frame  <= {1'b1, r_frame[9:1]};
                                    r_bitcnt <= r_bitcnt + 4'd1;
                                    if (r_bitcnt == 4'd9) begin
                                        r_state <= ST_ACK;
                                    end
                                end
                            end
                            ST_ACK: begin
                                r_dat_oe <= 1'b0;
                                if (w_fall) begin
                                    r_ack_ok <= ~w_dat;
                                    r_state  <= ST_WAIT_IDLE;
                                end
                            end
                            ST_WAIT_IDLE: begin
                                if (r_clk_filt && w_dat) begin
                                    r_busy  <= 1'b0;
                                    r_done  <= 1'b1;
                                    r_err   <= ~r_ack_ok;
                                    r_state <= ST_IDLE;
                                end
                            end
                            default: begin
                                r_clk_oe <= 1'b0;
                                r_dat_oe <= 1'b0;
                                r_busy   <= 1'b0;
                                r_state  <= ST_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_dat_oe  = r_dat_oe;
    assign bus.tx_busy = r_busy;
    assign bus.tx_done = r_done;
    assign bus.tx_err  = r_err;
    assign bus.rx_en   = ~r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_host_tx
//  Description : Directed/randomized bench for ps2_host_tx with an open-drain
//                PS/2 keyboard model and a frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int HALF = 30;

    logic clk = 1'b0;
    logic rst;
    logic dev_clk, dev_dat, dev_glitch;
    logic ps2_clk_oe, ps2_dat_oe;
    logic ps2_clk_in, ps2_dat_in;

    always #5 clk = ~clk;

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (16),
        .TIMEOUT_CYCLES (200)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .bus        (bus),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    // Open-drain pads with pull-ups.
    assign ps2_clk_in = ~ps2_clk_oe & dev_clk & ~dev_glitch;
    assign ps2_dat_in = ~ps2_dat_oe & dev_dat;

    int n_vec = 0;
    int n_err = 0;

    int cyc = 0;
    int clk_low_total = 0;
    int rx_bad = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic       done_err;
    logic [1:0] done_oe;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ps2_clk_oe === 1'b1) clk_low_total++;
        if (bus.rx_en !== ~bus.tx_busy) rx_bad++;
        if (bus.tx_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = bus.tx_err;
            done_oe  = {ps2_clk_oe, ps2_dat_oe};
        end
    end

    logic [9:0] got;
    logic       start_bit, mid_rx, n1_busy, n1_clkoe;
    logic       rts_seen;
    int         last_fall_cyc;
    int         b_done, b_low, b_rx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: frame = data LSB first, odd parity, stop bit 1.
    function automatic logic [9:0] model_frame(input logic [7:0] d);
        int   ones = 0;
        logic par;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        par = (ones % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, d};
    endfunction

    task automatic device_run(input int n_edges, input bit ack_low, input bit glitch,
                              input int extra_at, input int rst_at);
        int t = 0;
        got = '0;
        while (t < 2000 && !(ps2_clk_oe === 1'b0 && ps2_dat_oe === 1'b1)) begin
            @(negedge clk);
            t++;
        end
        rts_seen = (t < 2000);
        repeat (40) @(negedge clk);
        start_bit = ps2_dat_in;
        mid_rx    = bus.rx_en;
        for (int k = 1; k <= n_edges; k++) begin
            if (k == 11 && ack_low) dev_dat = 1'b0;
            dev_clk = 1'b0;
            last_fall_cyc = cyc;
            if (k == rst_at) begin
                repeat (12) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                dev_clk = 1'b1;
                return;
            end
            repeat (HALF) @(negedge clk);
            if (k == extra_at) begin
                bus.tx_data  = 8'h55;
                bus.tx_start = 1'b1;
            end
            dev_clk = 1'b1;
            if (k <= 10) got[k-1] = ps2_dat_in;
            @(negedge clk);
            bus.tx_start = 1'b0;
            if (glitch && k < 10) begin
                repeat (10) @(negedge clk);
                dev_glitch = 1'b1;
                repeat (3) @(negedge clk);
                dev_glitch = 1'b0;
                repeat (HALF - 14) @(negedge clk);
            end else begin
                repeat (HALF - 1) @(negedge clk);
            end
            if (k == 11) dev_dat = 1'b1;
        end
    endtask

    task automatic run_xfer(input logic [7:0] d, input int n_edges, input bit ack_low,
                            input bit glitch, input int extra_at, input int rst_at, input int bound);
        b_done = done_cnt;
        b_low  = clk_low_total;
        b_rx   = rx_bad;
        bus.tx_data  = d;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        n1_busy  = bus.tx_busy;
        n1_clkoe = ps2_clk_oe;
        device_run(n_edges, ack_low, glitch, extra_at, rst_at);
        if (rst_at == 0) begin
            for (int t = 0; t < bound && done_cnt == b_done; t++) @(negedge clk);
            repeat (5) @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0] d;
        bit         ack;
        int         dt;

        rst = 1'b1;
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        dev_glitch = 1'b0;
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (4) @(negedge clk);
        check("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("reset_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("reset_busy",   32'(bus.tx_busy), 32'd0);
        check("reset_done",   32'(bus.tx_done), 32'd0);
        check("reset_err",    32'(bus.tx_err),  32'd0);
        check("reset_rx_en",  32'(bus.rx_en),   32'd1);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        // 0xED, acked
        run_xfer(8'hED, 11, 1'b1, 1'b0, 0, 0, 600);
        check("ed_busy_n1",   32'(n1_busy),  32'd1);
        check("ed_clkoe_n1",  32'(n1_clkoe), 32'd1);
        check("ed_rts",       32'(rts_seen), 32'd1);
        check("ed_start_bit", 32'(start_bit), 32'd0);
        check("ed_rx_en_mid", 32'(mid_rx), 32'd0);
        check("ed_inhibit",   32'(clk_low_total - b_low), 32'd16);
        check("ed_frame",     32'(got), 32'(model_frame(8'hED)));
        check("ed_frame_lit", 32'(got), 32'h3ED);
        check("ed_done",      32'(done_cnt - b_done), 32'd1);
        check("ed_err",       32'(done_err), 32'd0);
        check("ed_rx_track",  32'(rx_bad - b_rx), 32'd0);
        check("ed_rx_en_end", 32'(bus.rx_en), 32'd1);

        // 0xF4: five ones, parity bit 0
        run_xfer(8'hF4, 11, 1'b1, 1'b0, 0, 0, 600);
        check("f4_frame",  32'(got), 32'(model_frame(8'hF4)));
        check("f4_parity", 32'(got[8]), 32'd0);
        check("f4_done",   32'(done_cnt - b_done), 32'd1);
        check("f4_err",    32'(done_err), 32'd0);

        // NACK
        run_xfer(8'hED, 11, 1'b0, 1'b0, 0, 0, 600);
        check("nack_done", 32'(done_cnt - b_done), 32'd1);
        check("nack_err",  32'(done_err), 32'd1);

        // Device stops after 4 edges: timeout (200 cycles + ~9 filter latency)
        run_xfer(8'($urandom), 4, 1'b1, 1'b0, 0, 0, 800);
        dt = done_cyc - last_fall_cyc;
        check("tmo_done",   32'(done_cnt - b_done), 32'd1);
        check("tmo_err",    32'(done_err), 32'd1);
        check("tmo_oe",     32'(done_oe), 32'd0);
        check("tmo_window", 32'(dt >= 205 && dt <= 212), 32'd1);
        check("tmo_idle",   32'(bus.tx_busy), 32'd0);

        // Extra tx_start during SHIFT is ignored
        d = 8'($urandom);
        run_xfer(d, 11, 1'b1, 1'b0, 3, 0, 600);
        check("xs_frame", 32'(got), 32'(model_frame(d)));
        check("xs_done",  32'(done_cnt - b_done), 32'd1);
        b_low = clk_low_total;
        repeat (60) @(negedge clk);
        check("xs_no_queue_busy", 32'(bus.tx_busy), 32'd0);
        check("xs_no_queue_clk",  32'(clk_low_total - b_low), 32'd0);

        // Reset at edge 6
        run_xfer(8'($urandom), 11, 1'b1, 1'b0, 0, 6, 0);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        check("rst_busy",   32'(bus.tx_busy), 32'd0);
        repeat (400) @(negedge clk);
        check("rst_no_done", 32'(done_cnt - b_done), 32'd0);

        // Clock glitches during SHIFT
        d = 8'($urandom);
        run_xfer(d, 11, 1'b1, 1'b1, 0, 0, 600);
        check("gl_frame", 32'(got), 32'(model_frame(d)));
        check("gl_done",  32'(done_cnt - b_done), 32'd1);
        check("gl_err",   32'(done_err), 32'd0);

        // Random bytes and acknowledge outcomes
        for (int i = 0; i < 6; i++) begin
            d   = 8'($urandom);
            ack = 1'($urandom_range(0, 1));
            run_xfer(d, 11, ack, 1'b0, 0, 0, 600);
            check("rnd_frame", 32'(got), 32'(model_frame(d)));
            check("rnd_done",  32'(done_cnt - b_done), 32'd1);
            check("rnd_err",   32'(done_err), 32'(!ack));
            check("rnd_rx",    32'(rx_bad - b_rx), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
